// File: rtl/match_clock_ctrl.sv
// Game-sequencing controller for the basketball scoreboard: period clock, shot clock,
// possession and period progression, with registered display-facing outputs.
module match_clock_ctrl #(
  parameter int unsigned TICK_DIV    = 50_000_000,
  parameter int unsigned PERIOD_SEC  = 600,
  parameter int unsigned SHOT_SEC    = 24,
  parameter int unsigned BREAK_SEC   = 60,
  parameter int unsigned NUM_PERIODS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_p,
  input  logic       pause_p,
  input  logic       made_p,
  input  logic       rebound_p,
  output logic [1:0] team_sel,
  output logic [7:0] led_period,
  output logic [9:0] game_sec,
  output logic [4:0] shot_sec,
  output logic [2:0] period_num,
  output logic       running,
  output logic       viol_p,
  output logic       game_over
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam int unsigned GW = 10;
  localparam int unsigned SW = 5;
  localparam int unsigned NW = 3;

  localparam logic [PW-1:0] TICK_LAST  = PW'(TICK_DIV - 1);
  localparam logic [GW-1:0] GAME_LOAD  = GW'(PERIOD_SEC);
  localparam logic [SW-1:0] SHOT_LOAD  = SW'(SHOT_SEC);
  localparam logic [GW-1:0] BREAK_LOAD = GW'(BREAK_SEC);
  localparam logic [NW-1:0] LAST_PER   = NW'(NUM_PERIODS);
  localparam logic [1:0]    TEAM_A     = 2'b01;
  localparam logic [1:0]    TEAM_B     = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_PAUSE,
    S_BREAK,
    S_OVER
  } state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] presc, presc_nxt;
  logic [GW-1:0] brk_cnt, brk_nxt;
  logic [1:0]    team_nxt;
  logic [7:0]    led_nxt;
  logic [GW-1:0] game_nxt;
  logic [SW-1:0] shot_nxt;
  logic [NW-1:0] period_nxt;
  logic          running_nxt;
  logic          viol_nxt;
  logic          over_nxt;
  logic          tick;
  logic          swap;

  assign tick = (presc == TICK_LAST);

  // State and all output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      presc      <= '0;
      brk_cnt    <= BREAK_LOAD;
      team_sel   <= TEAM_A;
      led_period <= 8'hFF;
      game_sec   <= GAME_LOAD;
      shot_sec   <= SHOT_LOAD;
      period_num <= NW'(1);
      running    <= 1'b0;
      viol_p     <= 1'b0;
      game_over  <= 1'b0;
    end else begin
      state      <= state_nxt;
      presc      <= presc_nxt;
      brk_cnt    <= brk_nxt;
      team_sel   <= team_nxt;
      led_period <= led_nxt;
      game_sec   <= game_nxt;
      shot_sec   <= shot_nxt;
      period_num <= period_nxt;
      running    <= running_nxt;
      viol_p     <= viol_nxt;
      game_over  <= over_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt  = state;
    presc_nxt  = presc;
    brk_nxt    = brk_cnt;
    team_nxt   = team_sel;
    led_nxt    = led_period;
    game_nxt   = game_sec;
    shot_nxt   = shot_sec;
    period_nxt = period_num;
    viol_nxt   = 1'b0;
    swap       = 1'b0;

    case (state)
      S_IDLE: begin
        presc_nxt = '0;
        if (start_p) begin
          state_nxt = S_RUN;
        end
      end

      S_RUN: begin
        presc_nxt = tick ? '0 : presc + PW'(1);
        if (tick && (game_sec == GW'(1))) begin
          // Period end wins over shot-clock and same-cycle events
          game_nxt  = '0;
          led_nxt   = led_period >> 2;
          presc_nxt = '0;
          if (period_num == LAST_PER) begin
            state_nxt = S_OVER;
          end else begin
            state_nxt = S_BREAK;
            brk_nxt   = BREAK_LOAD;
          end
        end else begin
          if (tick) begin
            game_nxt = game_sec - GW'(1);
            if (shot_sec == SW'(1)) begin
              viol_nxt = 1'b1;
              swap     = 1'b1;
              shot_nxt = SHOT_LOAD;
            end else begin
              shot_nxt = shot_sec - SW'(1);
            end
          end
          // A basket and a violation together still swap only once
          if (made_p || rebound_p) begin
            shot_nxt = SHOT_LOAD;
          end
          if (made_p) begin
            swap = 1'b1;
          end
          if (swap) begin
            team_nxt = {team_sel[0], team_sel[1]};
          end
          if (pause_p) begin
            state_nxt = S_PAUSE;
          end
        end
      end

      S_PAUSE: begin
        if (start_p || pause_p) begin
          state_nxt = S_RUN;
        end
      end

      S_BREAK: begin
        presc_nxt = tick ? '0 : presc + PW'(1);
        if (tick) begin
          if (brk_cnt <= GW'(1)) begin
            brk_nxt    = '0;
            period_nxt = period_num + NW'(1);
            game_nxt   = GAME_LOAD;
            shot_nxt   = SHOT_LOAD;
            team_nxt   = period_nxt[0] ? TEAM_A : TEAM_B;
            state_nxt  = S_PAUSE;
          end else begin
            brk_nxt = brk_cnt - GW'(1);
          end
        end
      end

      S_OVER: begin
        presc_nxt = '0;
      end

      default: begin
        state_nxt = S_IDLE;
        presc_nxt = '0;
      end
    endcase

    running_nxt = (state_nxt == S_RUN);
    over_nxt    = (state_nxt == S_OVER);
  end

endmodule

// File: tb/tb_match_clock_ctrl.sv
// Directed bench for match_clock_ctrl: a per-cycle vector table for the first period
// and break, then hand sequences for period 2, reset mid-break and a full game.
module tb_match_clock_ctrl;

  localparam int unsigned TICK_DIV    = 4;
  localparam int unsigned PERIOD_SEC  = 10;
  localparam int unsigned SHOT_SEC    = 3;
  localparam int unsigned BREAK_SEC   = 2;
  localparam int unsigned NUM_PERIODS = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_p, pause_p, made_p, rebound_p;
  logic [1:0] team_sel;
  logic [7:0] led_period;
  logic [9:0] game_sec;
  logic [4:0] shot_sec;
  logic [2:0] period_num;
  logic       running, viol_p, game_over;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  match_clock_ctrl #(
    .TICK_DIV   (TICK_DIV),
    .PERIOD_SEC (PERIOD_SEC),
    .SHOT_SEC   (SHOT_SEC),
    .BREAK_SEC  (BREAK_SEC),
    .NUM_PERIODS(NUM_PERIODS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start_p   (start_p),
    .pause_p   (pause_p),
    .made_p    (made_p),
    .rebound_p (rebound_p),
    .team_sel  (team_sel),
    .led_period(led_period),
    .game_sec  (game_sec),
    .shot_sec  (shot_sec),
    .period_num(period_num),
    .running   (running),
    .viol_p    (viol_p),
    .game_over (game_over)
  );

  typedef struct {
    logic       s, p, m, r;
    logic [1:0] team;
    int         game;
    int         shot;
    int         per;
    logic [7:0] led;
    logic       run;
    logic       viol;
  } vec_t;

  vec_t vq[$];

  function automatic void add(input logic s, p, m, r, input logic [1:0] team,
                              input int game, shot, per, input logic [7:0] led,
                              input logic run, viol);
    vec_t v;
    v.s = s; v.p = p; v.m = m; v.r = r;
    v.team = team; v.game = game; v.shot = shot; v.per = per;
    v.led = led; v.run = run; v.viol = viol;
    vq.push_back(v);
  endfunction

  // n quiet cycles whose expected outputs do not change
  function automatic void idle(input int n, input logic [1:0] team, input int game, shot,
                               per, input logic [7:0] led, input logic run);
    for (int k = 0; k < n; k++) add(0, 0, 0, 0, team, game, shot, per, led, run, 0);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock with pulses applied; outputs are settled 1 time unit after the edge
  task automatic cyc(input logic r, s, p, m, rb);
    @(negedge clk);
    rst = r; start_p = s; pause_p = p; made_p = m; rebound_p = rb;
    @(posedge clk);
    #1;
    rst = 1'b0; start_p = 1'b0; pause_p = 1'b0; made_p = 1'b0; rebound_p = 1'b0;
  endtask

  task automatic check_all(input string tag, input logic [1:0] team, input logic [7:0] led,
                           input int game, shot, per, input logic run, viol, over);
    chk({tag, " team_sel"},   32'(team_sel),   32'(team));
    chk({tag, " led_period"}, 32'(led_period), 32'(led));
    chk({tag, " game_sec"},   32'(game_sec),   32'(game));
    chk({tag, " shot_sec"},   32'(shot_sec),   32'(shot));
    chk({tag, " period_num"}, 32'(period_num), 32'(per));
    chk({tag, " running"},    32'(running),    32'(run));
    chk({tag, " viol_p"},     32'(viol_p),     32'(viol));
    chk({tag, " game_over"},  32'(game_over),  32'(over));
  endtask

  initial begin
    logic [7:0] led_exp;
    rst = 1'b1; start_p = 1'b0; pause_p = 1'b0; made_p = 1'b0; rebound_p = 1'b0;

    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    check_all("reset", 2'b01, 8'hFF, 10, 3, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    check_all("idle_hold", 2'b01, 8'hFF, 10, 3, 1, 0, 0, 0);

    // Period 1 and the following break, one vector per clock
    add(1, 0, 0, 0, 2'b01, 10, 3, 1, 8'hFF, 1, 0);
    idle(3, 2'b01, 10, 3, 1, 8'hFF, 1);
    add(0, 0, 0, 0, 2'b01, 9, 2, 1, 8'hFF, 1, 0);
    idle(3, 2'b01, 9, 2, 1, 8'hFF, 1);
    add(0, 0, 0, 0, 2'b01, 8, 1, 1, 8'hFF, 1, 0);
    idle(3, 2'b01, 8, 1, 1, 8'hFF, 1);
    add(0, 0, 0, 0, 2'b10, 7, 3, 1, 8'hFF, 1, 1);
    idle(3, 2'b10, 7, 3, 1, 8'hFF, 1);
    add(0, 0, 0, 0, 2'b10, 6, 2, 1, 8'hFF, 1, 0);
    add(0, 0, 0, 0, 2'b10, 6, 2, 1, 8'hFF, 1, 0);
    add(0, 0, 1, 0, 2'b01, 6, 3, 1, 8'hFF, 1, 0);
    add(0, 0, 0, 0, 2'b01, 6, 3, 1, 8'hFF, 1, 0);
    add(0, 0, 0, 0, 2'b01, 5, 2, 1, 8'hFF, 1, 0);
    add(0, 0, 0, 1, 2'b01, 5, 3, 1, 8'hFF, 1, 0);
    add(0, 1, 0, 0, 2'b01, 5, 3, 1, 8'hFF, 0, 0);
    add(0, 0, 1, 0, 2'b01, 5, 3, 1, 8'hFF, 0, 0);
    add(0, 0, 0, 0, 2'b01, 5, 3, 1, 8'hFF, 0, 0);
    add(1, 0, 0, 0, 2'b01, 5, 3, 1, 8'hFF, 1, 0);
    add(0, 0, 0, 0, 2'b01, 5, 3, 1, 8'hFF, 1, 0);
    add(0, 0, 0, 0, 2'b01, 4, 2, 1, 8'hFF, 1, 0);
    idle(3, 2'b01, 4, 2, 1, 8'hFF, 1);
    add(0, 0, 0, 0, 2'b01, 3, 1, 1, 8'hFF, 1, 0);
    add(0, 0, 0, 1, 2'b01, 3, 3, 1, 8'hFF, 1, 0);
    idle(2, 2'b01, 3, 3, 1, 8'hFF, 1);
    add(0, 0, 0, 0, 2'b01, 2, 2, 1, 8'hFF, 1, 0);
    add(1, 1, 0, 0, 2'b01, 2, 2, 1, 8'hFF, 0, 0);
    add(1, 0, 0, 0, 2'b01, 2, 2, 1, 8'hFF, 1, 0);
    idle(2, 2'b01, 2, 2, 1, 8'hFF, 1);
    add(0, 0, 0, 0, 2'b01, 1, 1, 1, 8'hFF, 1, 0);
    idle(3, 2'b01, 1, 1, 1, 8'hFF, 1);
    add(0, 0, 1, 0, 2'b01, 0, 1, 1, 8'h3F, 0, 0);
    add(1, 0, 0, 0, 2'b01, 0, 1, 1, 8'h3F, 0, 0);
    add(0, 1, 0, 0, 2'b01, 0, 1, 1, 8'h3F, 0, 0);
    idle(5, 2'b01, 0, 1, 1, 8'h3F, 0);
    add(0, 0, 0, 0, 2'b10, 10, 3, 2, 8'h3F, 0, 0);
    add(0, 0, 0, 0, 2'b10, 10, 3, 2, 8'h3F, 0, 0);

    foreach (vq[i]) begin
      cyc(0, vq[i].s, vq[i].p, vq[i].m, vq[i].r);
      check_all($sformatf("v%0d", i), vq[i].team, vq[i].led, vq[i].game, vq[i].shot,
                vq[i].per, vq[i].run, vq[i].viol, 0);
    end

    // Period 2: basket on the violation tick swaps possession exactly once
    cyc(0, 1, 0, 0, 0);
    for (int k = 0; k < 11; k++) cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    check_all("made_viol", 2'b01, 8'h3F, 7, 3, 2, 1, 1, 0);
    cyc(0, 0, 0, 0, 0);
    chk("viol_width", 32'(viol_p), 32'd0);

    // Pause two cycles after a tick, hold, then resume the partial second
    cyc(0, 0, 1, 0, 0);
    for (int k = 0; k < 20; k++) begin
      cyc(0, 0, 0, 0, 0);
      chk($sformatf("pause_freeze%0d", k), 32'(game_sec), 32'd7);
    end
    cyc(0, 1, 0, 0, 0);
    chk("resume running", 32'(running), 32'd1);
    cyc(0, 0, 0, 0, 0);
    chk("pre_tick game_sec", 32'(game_sec), 32'd7);
    cyc(0, 0, 0, 0, 0);
    chk("resume_tick game_sec", 32'(game_sec), 32'd6);
    chk("resume_tick shot_sec", 32'(shot_sec), 32'd2);

    for (int k = 0; k < 24; k++) cyc(0, 0, 0, 0, 0);
    chk("p2_end led_period", 32'(led_period), 32'h0F);
    chk("p2_end game_sec", 32'(game_sec), 32'd0);
    chk("p2_end running", 32'(running), 32'd0);
    chk("p2_end period_num", 32'(period_num), 32'd2);

    // Reset mid-break, with a simultaneous start pulse that must lose
    for (int k = 0; k < 3; k++) cyc(0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    check_all("mid_break_rst", 2'b01, 8'hFF, 10, 3, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    check_all("post_rst_idle", 2'b01, 8'hFF, 10, 3, 1, 0, 0, 0);

    // Full game from a fresh start
    led_exp = 8'hFF;
    for (int per = 1; per <= 4; per++) begin
      cyc(0, 1, 0, 0, 0);
      chk($sformatf("game p%0d running", per), 32'(running), 32'd1);
      for (int k = 0; k < 40; k++) cyc(0, 0, 0, 0, 0);
      led_exp = led_exp >> 2;
      chk($sformatf("game p%0d led_period", per), 32'(led_period), 32'(led_exp));
      chk($sformatf("game p%0d running_end", per), 32'(running), 32'd0);
      if (per < 4) begin
        chk($sformatf("game p%0d game_over", per), 32'(game_over), 32'd0);
        for (int k = 0; k < 8; k++) cyc(0, 0, 0, 0, 0);
        chk($sformatf("game p%0d next period", per), 32'(period_num), 32'(per + 1));
        chk($sformatf("game p%0d next team", per), 32'(team_sel),
            ((per + 1) % 2 == 1) ? 32'd1 : 32'd2);
        chk($sformatf("game p%0d game_sec", per), 32'(game_sec), 32'd10);
      end
    end
    chk("over game_over", 32'(game_over), 32'd1);
    chk("over period_num", 32'(period_num), 32'd4);
    chk("over game_sec", 32'(game_sec), 32'd0);

    cyc(0, 1, 0, 0, 0);
    for (int k = 0; k < 6; k++) cyc(0, 0, 0, 0, 0);
    chk("over_absorb game_over", 32'(game_over), 32'd1);
    chk("over_absorb running", 32'(running), 32'd0);
    chk("over_absorb led_period", 32'(led_period), 32'h00);
    chk("over_absorb game_sec", 32'(game_sec), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
